// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stall_ctrl: pipeline stall/bubble/flush and divide-busy control  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_rmem_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        j_b_stall_i,
  input  logic        ex_div_start_i,
  input  logic        bus_stall_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_target_i,
  output logic        if_stall_o,
  output logic        id_stall_o,
  output logic        ex_stall_o,
  output logic        mem_stall_o,
  output logic        wb_stall_o,
  output logic        ex_bubble_o,
  output logic        mem_bubble_o,
  output logic        flush_all_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        div_busy_o,
  output logic        div_done_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV      = 2'd1,
    ST_EXC_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  localparam logic [5:0] c_div_load = 6'(DIV_CYCLES - 1);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_redirect_pc;
  logic        w_load_use;
  logic        w_cnt_zero;

  assign w_load_use = ex_rmem_i && (ex_waddr_i != 5'd0) &&
                      ((ex_waddr_i == id_rs_i) || (ex_waddr_i == id_rt_i));
  assign w_cnt_zero    = (r_cnt == 6'd0);
  assign redirect_pc_o = r_redirect_pc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= ST_RUN;
      r_cnt         <= 6'd0;
      r_redirect_pc <= 32'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (exc_valid_i) begin
            r_redirect_pc <= exc_target_i;
            r_cnt         <= 6'd0;
            r_state       <= bus_stall_i ? ST_EXC_WAIT : ST_FLUSH;
          end else if (!bus_stall_i && ex_div_start_i) begin
            r_cnt   <= c_div_load;
            r_state <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (exc_valid_i) begin
            // The exception aborts the divide outright.
            r_redirect_pc <= exc_target_i;
            r_cnt         <= 6'd0;
            r_state       <= bus_stall_i ? ST_EXC_WAIT : ST_FLUSH;
          end else if (w_cnt_zero) begin
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        ST_EXC_WAIT: begin
          if (!bus_stall_i) r_state <= ST_FLUSH;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    if_stall_o       = 1'b0;
    id_stall_o       = 1'b0;
    ex_stall_o       = 1'b0;
    mem_stall_o      = 1'b0;
    wb_stall_o       = 1'b0;
    ex_bubble_o      = 1'b0;
    mem_bubble_o     = 1'b0;
    flush_all_o      = 1'b0;
    redirect_valid_o = 1'b0;
    div_busy_o       = 1'b0;
    div_done_o       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus_stall_i) begin
          {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, wb_stall_o} = 5'b11111;
        end else if (!exc_valid_i && !ex_div_start_i && (w_load_use || j_b_stall_i)) begin
          if_stall_o  = 1'b1;
          id_stall_o  = 1'b1;
          ex_bubble_o = 1'b1;
        end
      end
      ST_DIV: begin
        div_busy_o = 1'b1;
        div_done_o = w_cnt_zero && !exc_valid_i;
        if (bus_stall_i) begin
          {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, wb_stall_o} = 5'b11111;
        end else if (!exc_valid_i) begin
          if_stall_o = 1'b1;
          id_stall_o = 1'b1;
          // On the final cycle the quotient leaves EX, so EX/MEM takes it instead of a NOP.
          ex_stall_o   = !w_cnt_zero;
          mem_bubble_o = !w_cnt_zero;
        end
      end
      ST_EXC_WAIT: begin
        {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, wb_stall_o} = 5'b11111;
      end
      default: begin
        flush_all_o      = 1'b1;
        redirect_valid_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stall_ctrl: scoreboard bench for pipe_stall_ctrl              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_rmem, j_b_stall, ex_div_start, bus_stall, exc_valid;
  logic [4:0]  ex_waddr, id_rs, id_rt;
  logic [31:0] exc_target;
  logic        if_stall, id_stall, ex_stall, mem_stall, wb_stall;
  logic        ex_bubble, mem_bubble, flush_all, redirect_valid, div_busy, div_done;
  logic [31:0] redirect_pc;
  logic [10:0] w_out;

  // Output vector order: if id ex mem wb | exb memb | flush rv | busy done
  localparam logic [10:0] c_all0   = 11'b00000_00_00_00;
  localparam logic [10:0] c_stall5 = 11'b11111_00_00_00;
  localparam logic [10:0] c_haz    = 11'b11000_10_00_00;
  localparam logic [10:0] c_flush  = 11'b00000_00_11_00;
  localparam logic [10:0] c_divr   = 11'b11100_01_00_10;
  localparam logic [10:0] c_divbus = 11'b11111_00_00_10;
  localparam logic [10:0] c_divd   = 11'b11000_00_00_11;
  localparam logic [10:0] c_divexc = 11'b00000_00_00_10;

  typedef struct {
    string       tag;
    logic [10:0] vec;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(32)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .ex_rmem_i(ex_rmem), .ex_waddr_i(ex_waddr), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .j_b_stall_i(j_b_stall), .ex_div_start_i(ex_div_start), .bus_stall_i(bus_stall),
    .exc_valid_i(exc_valid), .exc_target_i(exc_target),
    .if_stall_o(if_stall), .id_stall_o(id_stall), .ex_stall_o(ex_stall),
    .mem_stall_o(mem_stall), .wb_stall_o(wb_stall),
    .ex_bubble_o(ex_bubble), .mem_bubble_o(mem_bubble),
    .flush_all_o(flush_all), .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc), .div_busy_o(div_busy), .div_done_o(div_done)
  );

  assign w_out = {if_stall, id_stall, ex_stall, mem_stall, wb_stall,
                  ex_bubble, mem_bubble, flush_all, redirect_valid, div_busy, div_done};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic rmem, input logic [4:0] waddr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic jb, input logic divs,
                        input logic bus, input logic exc, input logic [31:0] tgt);
    ex_rmem = rmem; ex_waddr = waddr; id_rs = rs; id_rt = rt; j_b_stall = jb;
    ex_div_start = divs; bus_stall = bus; exc_valid = exc; exc_target = tgt;
  endtask

  task automatic idle_in();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Expectation is queued with the stimulus, then compared mid-cycle.
  task automatic cyc(input string tag, input logic [10:0] v, input logic [31:0] pc);
    exp_t e;
    e.tag = tag; e.vec = v; e.pc = pc;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_val({e.tag, "_out"}, {21'd0, w_out}, {21'd0, e.vec});
    check_val({e.tag, "_pc"}, redirect_pc, e.pc);
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic [31:0] pc);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc("div_start", c_all0, pc);
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    cyc("reset", c_all0, 32'd0);
    rst_n = 1'b1;
    cyc("idle", c_all0, 32'd0);

    // Load-use and branch hazards
    set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("lu_rt", c_haz, 32'd0);
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("lu_r0", c_all0, 32'd0);
    set_in(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("lu_rs", c_haz, 32'd0);
    set_in(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("lu_noload", c_all0, 32'd0);
    set_in(1'b1, 5'd9, 5'd8, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("lu_nomatch", c_all0, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("jb", c_haz, 32'd0);
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc("bus_over_haz", c_stall5, 32'd0);
    idle_in();

    // Full divide with a bus stall at cnt=20
    start_div(32'd0);
    for (int i = 31; i >= 1; i--) begin
      bus_stall = (i == 20);
      cyc("div_run", (i == 20) ? c_divbus : c_divr, 32'd0);
    end
    bus_stall = 1'b0;
    cyc("div_done", c_divd, 32'd0);
    cyc("div_after", c_all0, 32'd0);

    // Exception aborts divide at cnt=10
    start_div(32'd0);
    for (int i = 31; i >= 11; i--) cyc("div2_run", c_divr, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380);
    cyc("div2_exc", c_divexc, 32'd0);
    idle_in();
    cyc("div2_flush", c_flush, 32'hBFC0_0380);
    cyc("div2_run_after", c_all0, 32'hBFC0_0380);
    cyc("div2_nodone", c_all0, 32'hBFC0_0380);

    // Exception held off by a 3-cycle bus stall; second exception ignored
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0180);
    cyc("ew_enter", c_stall5, 32'hBFC0_0380);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    cyc("ew_wait1", c_stall5, 32'h8000_0180);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc("ew_wait2", c_stall5, 32'h8000_0180);
    idle_in();
    cyc("ew_release", c_stall5, 32'h8000_0180);
    ex_div_start = 1'b1;
    cyc("ew_flush", c_flush, 32'h8000_0180);
    idle_in();
    cyc("ew_run", c_all0, 32'h8000_0180);

    // Exception + divide start + load-use together
    set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
    cyc("combo", c_all0, 32'h8000_0180);
    idle_in();
    cyc("combo_flush", c_flush, 32'hBFC0_0200);
    cyc("combo_run", c_all0, 32'hBFC0_0200);

    // Reset mid-divide at cnt=5
    start_div(32'hBFC0_0200);
    for (int i = 31; i >= 6; i--) cyc("div3_run", c_divr, 32'hBFC0_0200);
    rst_n = 1'b0;
    cyc("div3_reset", c_all0, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc("div3_after", c_all0, 32'd0);

    // Exception during divide while the bus is stalled
    start_div(32'd0);
    cyc("div4_run", c_divr, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0ABC);
    cyc("div4_exc_bus", c_divbus, 32'd0);
    idle_in();
    cyc("div4_wait", c_stall5, 32'h0000_0ABC);
    cyc("div4_flush", c_flush, 32'h0000_0ABC);
    cyc("div4_run_after", c_all0, 32'h0000_0ABC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of cycles a div/divu occupies EX.
REQ-002 SHALL have ports in this order:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- ex_rmem_i  in  1  EX instruction is a load.
- ex_waddr_i  in  5  EX destination register.
- id_rs_i  in  5  ID source register rs.
- id_rt_i  in  5  ID source register rt.
- j_b_stall_i  in  1  branch/jump operand-hazard request from ID.
- ex_div_start_i  in  1  div/divu entering EX this cycle.
- bus_stall_i  in  1  instruction or data bus not ready.
- exc_valid_i  in  1  exception or eret committing in MEM.
- exc_target_i  in  32  redirect PC for exc_valid_i.
- if_stall_o  out  1  hold PC/IF.
- id_stall_o  out  1  hold IF/ID register; drives ID id_stall_i.
- ex_stall_o  out  1  hold ID/EX register.
- mem_stall_o  out  1  hold EX/MEM register.
- wb_stall_o  out  1  hold MEM/WB register.
- ex_bubble_o  out  1  load NOP into ID/EX.
- mem_bubble_o  out  1  load NOP into EX/MEM.
- flush_all_o  out  1  clear IF/ID, ID/EX, EX/MEM.
- redirect_valid_o  out  1  PC takes redirect_pc_o.
- redirect_pc_o  out  32  latched exception target.
- div_busy_o  out  1  divide in progress.
- div_done_o  out  1  one-cycle pulse, divide finished.

Function
REQ-003 SHALL implement FSM states RUN, DIV, EXC_WAIT, FLUSH; registered state, 6-bit down-counter cnt, 32-bit redirect_pc_o.
REQ-004 Priority per cycle SHALL be: exception > bus_stall_i > divide > load-use / j_b_stall_i.
REQ-005 RUN, exc_valid_i=1, bus_stall_i=0: SHALL latch exc_target_i into redirect_pc_o; next state FLUSH.
REQ-006 RUN or DIV, exc_valid_i=1, bus_stall_i=1: SHALL latch exc_target_i; next state EXC_WAIT; all five stall outputs 1.
REQ-007 EXC_WAIT: SHALL keep all stalls 1 while bus_stall_i=1; next state FLUSH on first cycle with bus_stall_i=0; further exc_valid_i ignored, latched target unchanged.
REQ-008 FLUSH: exactly one cycle with flush_all_o=1, redirect_valid_o=1, all stalls 0; ex_div_start_i ignored; next state RUN.
REQ-009 RUN, no exception, bus_stall_i=1: all five stall outputs 1, no bubbles, state unchanged.
REQ-010 RUN, no exception, no bus stall, ex_div_start_i=1: next state DIV, cnt loaded with DIV_CYCLES-1.
REQ-011 DIV: if/id/ex stall outputs 1, mem/wb stall 0, mem_bubble_o=1, div_busy_o=1; cnt decrements every cycle, including during bus_stall_i.
REQ-012 DIV with bus_stall_i=1: all five stalls 1, mem_bubble_o=0.
REQ-013 DIV at cnt=0: div_done_o=1 that cycle; ex_stall_o=0; next state RUN.
REQ-014 Exception during DIV SHALL abort the divide: div_done_o never pulses; cnt cleared.
REQ-015 Load-use hazard = ex_rmem_i & (ex_waddr_i!=0) & (ex_waddr_i==id_rs_i | ex_waddr_i==id_rt_i).
REQ-016 RUN, load-use or j_b_stall_i, with no higher-priority event: if_stall_o=1, id_stall_o=1, ex_bubble_o=1, other stalls 0; combinational, no state change.
REQ-017 All outputs except redirect_pc_o SHALL be decoded from state and inputs, with no added cycle of latency.
REQ-018 redirect_valid_o and flush_all_o SHALL never assert outside FLUSH.
REQ-019 ex_bubble_o and mem_bubble_o SHALL never assert with flush_all_o.

Reset
REQ-020 rst_i=0 SHALL immediately force state=RUN, cnt=0, redirect_pc_o=0.
REQ-021 During reset, with all inputs 0, every 1-bit output SHALL be 0.
REQ-022 Reset during DIV, EXC_WAIT or FLUSH SHALL abandon the operation with no div_done_o or redirect pulse.

Verification
REQ-023 Load-use: ex_rmem_i=1, ex_waddr_i=5, id_rt_i=5 -> if_stall_o=id_stall_o=ex_bubble_o=1 same cycle; with ex_waddr_i=0 -> all 0.
REQ-024 Divide: ex_div_start_i pulse, DIV_CYCLES=32 -> div_busy_o high 32 cycles, div_done_o on the 32nd, RUN next.
REQ-025 Exception in DIV at cnt=10, bus_stall_i=0, exc_target_i=0xBFC00380 -> next cycle FLUSH with redirect_pc_o=0xBFC00380, no div_done_o.
REQ-026 Exception with bus_stall_i high 3 cycles -> EXC_WAIT with all stalls 1, then one FLUSH cycle, then RUN; a second exc_valid_i during the wait leaves the target unchanged.
REQ-027 rst_i dropped mid-DIV at cnt=5 -> state RUN immediately, div_busy_o=0, no div_done_o after release.
REQ-028 Simultaneous exc_valid_i, ex_div_start_i and load-use in RUN -> FLUSH only; no DIV entry, no ex_bubble_o.
